// File: rtl/multi_channel_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_channel_monitor                                        |
// | Description : CHANNELS independent up/down device-group counters, a        |
// |               registered aggregate total and a hysteretic high-occupancy   |
// |               alarm.                                                       |
// | Options     : define PEAK_HOLD_EN to add a peak-hold register on total     |
// |               (adds ports peak_clr / peak).                                |
// | Ports       : clk        - rising-edge clock                               |
// |               rst_n      - asynchronous active-low reset                   |
// |               clear      - synchronous clear of counts/total/alarm         |
// |               change     - per-channel count strobe                        |
// |               on_off     - per-channel direction (1 = up, 0 = down)        |
// |               count_flat - channel i count at [i*WIDTH +: WIDTH]           |
// |               total      - registered sum of all channel counts            |
// |               limit_evt  - 1-cycle pulse when a channel hits a limit       |
// |               alarm      - hysteretic high-occupancy alarm                 |
// |               peak_clr   - (PEAK_HOLD_EN) reload peak with current total   |
// |               peak       - (PEAK_HOLD_EN) max total since reset/clear      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multi_channel_monitor #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int HI_THRESH = 200,
  parameter int LO_THRESH = 150,
  localparam int TW       = WIDTH + $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       change,
  input  logic [CHANNELS-1:0]       on_off,
  output logic [CHANNELS*WIDTH-1:0] count_flat,
  output logic [TW-1:0]             total,
  output logic [CHANNELS-1:0]       limit_evt,
  output logic                      alarm
`ifdef PEAK_HOLD_EN
  ,
  input  logic                      peak_clr,
  output logic [TW-1:0]             peak
`endif
);

  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
  localparam logic             c_saturate = (SATURATE != 0);
  localparam logic [TW-1:0]    c_hi       = TW'(HI_THRESH);
  localparam logic [TW-1:0]    c_lo       = TW'(LO_THRESH);

  localparam logic [0:0] c_st_normal = 1'b0;
  localparam logic [0:0] c_st_alarm  = 1'b1;

  logic [WIDTH-1:0] w_cnt [CHANNELS];
  logic [TW-1:0]    w_sum;
  logic [TW-1:0]    r_total;
  logic [0:0]       r_state;

  // --------------------------------------------------------------------------
  // Per-channel counters
  // --------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [WIDTH-1:0] r_cnt;
    logic             r_limit;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_hit;

    assign w_at_max = &r_cnt;
    assign w_at_min = ~|r_cnt;
    // A limit is only "hit" when this cycle's step would cross it.
    assign w_hit    = change[gi] & (on_off[gi] ? w_at_max : w_at_min);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_limit <= 1'b0;
      end else if (clear) begin
        r_cnt   <= '0;
        r_limit <= 1'b0;
      end else begin
        r_limit <= w_hit;
        // Wrap mode relies on natural modulo-2^WIDTH arithmetic; clamp mode
        // simply skips the step when it would cross the limit.
        if (change[gi] && !(w_hit && c_saturate)) begin
          r_cnt <= on_off[gi] ? (r_cnt + c_one) : (r_cnt - c_one);
        end
      end
    end

    assign w_cnt[gi]                      = r_cnt;
    assign count_flat[gi*WIDTH +: WIDTH]  = r_cnt;
    assign limit_evt[gi]                  = r_limit;
  end

  // --------------------------------------------------------------------------
  // Aggregate total (TW bits cannot overflow: CHANNELS*(2^WIDTH-1) fits)
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sum = w_sum + TW'(w_cnt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= '0;
    end else if (clear) begin
      r_total <= '0;
    end else begin
      r_total <= w_sum;
    end
  end

  assign total = r_total;

  // --------------------------------------------------------------------------
  // Hysteretic alarm FSM, driven from the registered total
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_normal;
    end else if (clear) begin
      r_state <= c_st_normal;
    end else begin
      case (r_state)
        c_st_normal: if (r_total >= c_hi) r_state <= c_st_alarm;
        c_st_alarm:  if (r_total <= c_lo) r_state <= c_st_normal;
        default:     r_state <= c_st_normal;
      endcase
    end
  end

  assign alarm = (r_state == c_st_alarm);

`ifdef PEAK_HOLD_EN
  // --------------------------------------------------------------------------
  // Peak hold on the registered total
  // --------------------------------------------------------------------------
  logic [TW-1:0] r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (clear) begin
      r_peak <= '0;
    end else if (peak_clr) begin
      r_peak <= r_total;
    end else if (r_total > r_peak) begin
      r_peak <= r_total;
    end
  end

  assign peak = r_peak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multi_channel_monitor                                     |
// | Description : Self-checking bench for multi_channel_monitor. Two instances |
// |               (wrap and clamp) share stimulus; a behavioural model tracks  |
// |               expected counts, total, limit pulses, alarm and peak.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multi_channel_monitor;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int TW   = 10;
  localparam int HI   = 200;
  localparam int LO   = 150;
  localparam int MAXC = 255;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          clear    = 1'b0;
  logic [CH-1:0] change   = '0;
  logic [CH-1:0] on_off   = '0;
  logic          peak_clr = 1'b0;

  logic [CH*W-1:0] cf0, cf1;
  logic [TW-1:0]   tot0, tot1;
  logic [CH-1:0]   lev0, lev1;
  logic            alm0, alm1;
  logic [TW-1:0]   pk0, pk1;

  always #5 clk = ~clk;

  multi_channel_monitor #(.CHANNELS(CH), .WIDTH(W), .SATURATE(0),
                          .HI_THRESH(HI), .LO_THRESH(LO)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .change(change), .on_off(on_off),
    .count_flat(cf0), .total(tot0), .limit_evt(lev0), .alarm(alm0)
`ifdef PEAK_HOLD_EN
    , .peak_clr(peak_clr), .peak(pk0)
`endif
  );

  multi_channel_monitor #(.CHANNELS(CH), .WIDTH(W), .SATURATE(1),
                          .HI_THRESH(HI), .LO_THRESH(LO)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .change(change), .on_off(on_off),
    .count_flat(cf1), .total(tot1), .limit_evt(lev1), .alarm(alm1)
`ifdef PEAK_HOLD_EN
    , .peak_clr(peak_clr), .peak(pk1)
`endif
  );

`ifndef PEAK_HOLD_EN
  assign pk0 = '0;
  assign pk1 = '0;
`endif

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // index 0 = wrap instance, 1 = clamp instance
  int m_cnt [2][CH];
  int m_tot [2];
  int m_pk  [2];
  bit m_alm [2];
  bit [CH-1:0] m_lev [2];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < CH; c++) m_cnt[s][c] = 0;
      m_tot[s] = 0; m_pk[s] = 0; m_alm[s] = 1'b0; m_lev[s] = '0;
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs present now.
  task automatic model_step();
    for (int s = 0; s < 2; s++) begin
      int sum;
      bit nalm;
      int npk;
      sum = 0;
      for (int c = 0; c < CH; c++) sum += m_cnt[s][c];
      if (m_alm[s]) nalm = !(m_tot[s] <= LO);
      else          nalm = (m_tot[s] >= HI);
      if (peak_clr) npk = m_tot[s];
      else          npk = (m_tot[s] > m_pk[s]) ? m_tot[s] : m_pk[s];
      if (clear) begin
        for (int c = 0; c < CH; c++) m_cnt[s][c] = 0;
        m_tot[s] = 0; m_pk[s] = 0; m_alm[s] = 1'b0; m_lev[s] = '0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          m_lev[s][c] = 1'b0;
          if (change[c]) begin
            if (on_off[c]) begin
              if (m_cnt[s][c] == MAXC) begin
                m_lev[s][c] = 1'b1;
                m_cnt[s][c] = (s == 1) ? MAXC : 0;
              end else m_cnt[s][c]++;
            end else begin
              if (m_cnt[s][c] == 0) begin
                m_lev[s][c] = 1'b1;
                m_cnt[s][c] = (s == 1) ? 0 : MAXC;
              end else m_cnt[s][c]--;
            end
          end
        end
        m_tot[s] = sum; m_alm[s] = nalm; m_pk[s] = npk;
      end
    end
  endtask

  function automatic logic [CH*W-1:0] exp_flat(input int s);
    logic [CH*W-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[c*W +: W] = W'(m_cnt[s][c]);
    return v;
  endfunction

  task automatic compare_all(input string ph);
    check({ph, " wrap.count_flat"}, 64'(cf0), 64'(exp_flat(0)));
    check({ph, " wrap.total"},      64'(tot0), 64'(m_tot[0]));
    check({ph, " wrap.limit_evt"},  64'(lev0), 64'(m_lev[0]));
    check({ph, " wrap.alarm"},      64'(alm0), 64'(m_alm[0]));
    check({ph, " sat.count_flat"},  64'(cf1), 64'(exp_flat(1)));
    check({ph, " sat.total"},       64'(tot1), 64'(m_tot[1]));
    check({ph, " sat.limit_evt"},   64'(lev1), 64'(m_lev[1]));
    check({ph, " sat.alarm"},       64'(alm1), 64'(m_alm[1]));
`ifdef PEAK_HOLD_EN
    check({ph, " wrap.peak"},       64'(pk0), 64'(m_pk[0]));
    check({ph, " sat.peak"},        64'(pk1), 64'(m_pk[1]));
`endif
  endtask

  task automatic step(input string ph, input logic [CH-1:0] chg, input logic [CH-1:0] dir,
                      input logic clr, input logic pclr);
    @(negedge clk);
    change = chg; on_off = dir; clear = clr; peak_clr = pclr;
    @(posedge clk);
    model_step();
    #1;
    compare_all(ph);
  endtask

  task automatic idle(input string ph, input int n);
    for (int k = 0; k < n; k++) step(ph, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Five up-counts on channel 0, total follows one edge later
    step("clr", '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step("ch0_up", 4'b0001, 4'b0001, 1'b0, 1'b0);
    check("ch0_count_5", 64'(cf0[W-1:0]), 64'd5);
    idle("ch0_tot", 1);
    check("ch0_total_5", 64'(tot0), 64'd5);

    // All channels to 37, then asynchronous reset mid-cycle
    step("clr", '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 37; k++) step("to37", '1, '1, 1'b0, 1'b0);
    check("all37_ch3", 64'(cf0[3*W +: W]), 64'd37);
    @(negedge clk);
    change = '0; on_off = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    check("async_rst_flat", 64'(cf1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 1 to 255, then up at top and down at bottom
    step("clr", '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 255; k++) step("ch1_up", 4'b0010, 4'b0010, 1'b0, 1'b0);
    check("ch1_at_255", 64'(cf0[W +: W]), 64'd255);
    step("ch1_top", 4'b0010, 4'b0010, 1'b0, 1'b0);
    check("wrap_255p1", 64'(cf0[W +: W]), 64'd0);
    check("wrap_lim1", 64'(lev0[1]), 64'd1);
    check("sat_255p1", 64'(cf1[W +: W]), 64'd255);
    check("sat_lim1", 64'(lev1[1]), 64'd1);
    idle("ch1_idle", 1);
    check("lim1_drop", 64'(lev0[1]), 64'd0);
    step("ch1_dn0", 4'b0010, 4'b0000, 1'b0, 1'b0);
    check("wrap_0m1", 64'(cf0[W +: W]), 64'd255);
    check("wrap_0m1_lim", 64'(lev0[1]), 64'd1);

    // Channel 2 down from 0
    step("clr", '0, '0, 1'b1, 1'b0);
    step("ch2_dn0", 4'b0100, 4'b0000, 1'b0, 1'b0);
    check("sat_0m1", 64'(cf1[2*W +: W]), 64'd0);
    check("sat_lim2", 64'(lev1[2]), 64'd1);
    check("wrap_0m1_ch2", 64'(cf0[2*W +: W]), 64'd255);

    // Alarm hysteresis: 149 -> 200 -> 151 -> 150
    step("clr", '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 149; k++) step("ramp149", 4'b0001, 4'b0001, 1'b0, 1'b0);
    idle("hold149", 2);
    check("tot149", 64'(tot0), 64'd149);
    check("alm149", 64'(alm0), 64'd0);
    for (int k = 0; k < 51; k++) step("ramp200", 4'b0010, 4'b0010, 1'b0, 1'b0);
    idle("tot200", 1);
    check("tot200", 64'(tot0), 64'd200);
    check("alm_pre", 64'(alm0), 64'd0);
    idle("alm200", 1);
    check("alm200", 64'(alm0), 64'd1);
    for (int k = 0; k < 49; k++) step("drop151", 4'b0010, 4'b0000, 1'b0, 1'b0);
    idle("hold151", 3);
    check("tot151", 64'(tot0), 64'd151);
    check("alm151", 64'(alm0), 64'd1);
    step("drop150", 4'b0010, 4'b0000, 1'b0, 1'b0);
    idle("tot150", 1);
    check("tot150", 64'(tot0), 64'd150);
    check("alm150_pre", 64'(alm0), 64'd1);
    idle("alm150", 1);
    check("alm150", 64'(alm0), 64'd0);

    // Clear wins over simultaneous changes
    step("clr_chg", '1, '1, 1'b1, 1'b0);
    check("clr_flat", 64'(cf0), 64'd0);
    check("clr_total", 64'(tot0), 64'd0);
    check("clr_alarm", 64'(alm0), 64'd0);
    for (int k = 0; k < 3; k++) step("pk_up", '1, '1, 1'b0, 1'b0);
    idle("pk_settle", 2);
    check("pk_tot12", 64'(tot0), 64'd12);
    for (int k = 0; k < 2; k++) step("pk_dn", '1, '0, 1'b0, 1'b0);
    idle("pk_settle2", 2);
    check("pk_tot4", 64'(tot0), 64'd4);
`ifdef PEAK_HOLD_EN
    check("peak_hold12", 64'(pk0), 64'd12);
`endif

    // Randomised traffic: up-biased then down-biased, occasional clear/peak_clr
    step("clr", '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      logic [CH-1:0] chg, dir;
      int bias;
      bias = (k < 1500) ? 75 : 25;
      chg  = CH'($urandom);
      for (int c = 0; c < CH; c++) dir[c] = ($urandom_range(99) < bias);
      step("rand", chg, dir, ($urandom_range(255) == 0), ($urandom_range(31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
